// File: rtl/image_stream_reader_pkg.sv
// Shared types and address-map constants for the image stream reader.
package img_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REG_GENERAL = 3'b000;
  localparam logic [2:0] REG_IN0     = 3'b001;
  localparam logic [2:0] REG_IN1     = 3'b010;
  localparam logic [2:0] REG_IN2     = 3'b011;
  localparam logic [2:0] REG_OUT0    = 3'b100;
  localparam logic [2:0] REG_OUT1    = 3'b101;
  localparam logic [2:0] REG_OUT2    = 3'b110;
  localparam logic [2:0] REG_PERIPH  = 3'b111;

  localparam int REGION_LSB = 16;
  localparam int REGION_MSB = 18;

endpackage

// File: rtl/image_stream_reader_stream_fifo.sv
// Small power-of-two FIFO buffering returned pixels ahead of the sink.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/image_stream_reader.sv
// Reads a run of pixels from one memory region over the shared bus and streams them out.
// Optional IMG_STREAM_CHECKSUM_EN adds checksum_o, the 16-bit sum of accepted pixels.
//
//  state | meaning
//  IDLE  | waiting for start_i
//  RUN   | issuing reads while FIFO credit allows
//  DRAIN | all reads issued, waiting for the last pixel to be accepted
//  DONE  | one-cycle completion pulse
module image_stream_reader
  import img_stream_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic [2:0]        region_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [31:0]       mem_addr_o,
  output logic              mem_wren_o,
  input  logic [31:0]       mem_data_i,
  output logic [7:0]        pix_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef IMG_STREAM_CHECKSUM_EN
  ,output logic [15:0]      checksum_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic [2:0]          region_q;
  logic [ADDR_W:0]     rem_q;
  logic [ADDR_W-1:0]   off_q;
  logic [31:0]         addr_q;
  logic [RD_LAT-1:0]   sh_q;

  logic [CNT_W-1:0]    fifo_cnt;
  logic [CNT_W-1:0]    infl;
  logic                fifo_empty;
  logic [7:0]          fifo_head;
  logic                issue;
  logic                push;
  logic                pop;
  logic                last_pop;
  logic [31:0]         addr_nxt;
  logic [ADDR_W:0]     cnt_sat;
  logic                unused_full;
  logic                unused_data;

  assign unused_data = ^mem_data_i[31:8];

  always_comb begin
    infl     = CNT_W'($countones(sh_q));
    issue    = (state_q == RUN) && ((fifo_cnt + infl) < CNT_W'(FIFO_DEPTH));
    push     = sh_q[RD_LAT-1];
    pop      = pix_valid_o && pix_ready_i;
    // all reads are out in DRAIN, so an empty pipe plus one entry is the final pixel
    last_pop = pop && (fifo_cnt == CNT_W'(1)) && (infl == '0);
    addr_nxt = '0;
    addr_nxt[REGION_MSB:REGION_LSB] = region_q;
    addr_nxt[ADDR_W-1:0] = off_q;
    cnt_sat  = (count_i > CNT_MAX) ? CNT_MAX : count_i;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      region_q <= REG_GENERAL;
      rem_q    <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      sh_q     <= '0;
    end else begin
      sh_q <= RD_LAT'({sh_q, issue});
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (count_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              region_q <= region_i;
              rem_q    <= cnt_sat;
              off_q    <= '0;
              state_q  <= RUN;
              busy_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q <= addr_nxt;
            off_q  <= off_q + ADDR_W'(1);
            rem_q  <= rem_q - (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .wdata_i (mem_data_i[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty),
    .full_o  (unused_full)
  );

  assign mem_addr_o  = addr_q;
  assign mem_wren_o  = 1'b0;
  assign pix_valid_o = !fifo_empty;
  assign pix_o       = fifo_empty ? 8'h00 : fifo_head;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef IMG_STREAM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sum_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + {8'h00, pix_o};
    end
  end

  assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: directed transfers, transfer-level model checked every cycle.
module tb_image_stream_reader;
  import img_stream_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  region_i = 3'b000;
  logic [16:0] count_i = '0;
  logic        pix_ready_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_addr_o;
  logic        mem_wren_o;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        busy_o;
  logic        done_o;
`ifdef IMG_STREAM_CHECKSUM_EN
  logic [15:0] checksum_o;
  logic [15:0] cs_at_done = '0;
`endif

  logic [7:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // memory registers its read data on the falling edge
  always @(negedge CLK) mem_data_i <= {24'h0, mem[mem_addr_o[9:0]]};

  image_stream_reader dut (
    .CLK         (CLK),
    .RST         (RST),
    .start_i     (start_i),
    .region_i    (region_i),
    .count_i     (count_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wren_o  (mem_wren_o),
    .mem_data_i  (mem_data_i),
    .pix_o       (pix_o),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef IMG_STREAM_CHECKSUM_EN
    ,.checksum_o (checksum_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: which transfer is active, how many reads issued/pixels accepted.
  bit          model_en = 1'b0;
  bit          active = 1'b0;
  bit          done_now = 1'b0;
  bit          done_nxt;
  bit          act_nxt;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [7:0]  prev_pix = '0;
  logic [31:0] prev_addr = '0;
  logic [2:0]  reg_exp = '0;
  int          n_exp = 0;
  int          iss = 0;
  int          acc = 0;

  always @(negedge CLK) begin
    if (model_en) begin
      if (!RST) begin
        active     = 1'b0;
        done_now   = 1'b0;
        prev_valid = 1'b0;
        prev_addr  = '0;
      end else begin
        chk("wren", {31'b0, mem_wren_o}, 32'd0);
        chk("busy", {31'b0, busy_o}, {31'b0, active});
        chk("done", {31'b0, done_o}, {31'b0, done_now});
        if (!active) chk("valid_idle", {31'b0, pix_valid_o}, 32'd0);
        if (prev_valid && !prev_ready) begin
          chk("hold_valid", {31'b0, pix_valid_o}, 32'd1);
          chk("hold_pix", {24'b0, pix_o}, {24'b0, prev_pix});
        end
        if (mem_addr_o !== prev_addr) begin
          chk("issue_allowed", {31'b0, (active && iss < n_exp)}, 32'd1);
          if (active && iss < n_exp) begin
            chk("addr", mem_addr_o, {13'b0, reg_exp, 16'(iss)});
            iss++;
          end
        end
        chk("credit", {31'b0, ((iss - acc) <= 4)}, 32'd1);
        prev_addr = mem_addr_o;
        done_nxt = 1'b0;
        act_nxt  = active;
        if (active && pix_valid_o && pix_ready_i) begin
          chk("pix", {24'b0, pix_o}, {24'b0, mem[10'(acc)]});
          acc++;
          if (acc == n_exp) begin
            done_nxt = 1'b1;
            act_nxt  = 1'b0;
          end
        end
        if (!active && !done_now && start_i) begin
          reg_exp = region_i;
          n_exp   = (int'(count_i) > 65536) ? 65536 : int'(count_i);
          iss     = 0;
          acc     = 0;
          if (n_exp == 0) done_nxt = 1'b1;
          else act_nxt = 1'b1;
        end
        active     = act_nxt;
        done_now   = done_nxt;
        prev_valid = pix_valid_o;
        prev_ready = pix_ready_i;
        prev_pix   = pix_o;
      end
    end
  end

  // mode 0: ready high; mode 1: ready 1,0,0 repeating; mode 2: ready high plus a stray start
  task automatic run_xfer(input logic [2:0] r, input logic [16:0] c, input int mode, input int maxc);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    @(posedge CLK); #1;
    start_i  = 1'b1;
    region_i = r;
    count_i  = c;
    @(posedge CLK); #1;
    start_i = 1'b0;
    while (!seen && cyc < maxc) begin
      pix_ready_i = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2 && cyc == 3) begin
        start_i  = 1'b1;
        region_i = REG_IN2;
        count_i  = 17'd2;
      end else begin
        start_i  = 1'b0;
        region_i = r;
      end
      @(negedge CLK);
      if (done_o) begin
        seen = 1'b1;
`ifdef IMG_STREAM_CHECKSUM_EN
        cs_at_done = checksum_o;
`endif
      end
      @(posedge CLK); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] a_tab [0:6];
    logic [7:0]  p_tab [0:6];
    logic        v_tab [0:6];
    logic        b_tab [0:6];
    logic        d_tab [0:6];
    a_tab = '{32'h0, 32'h40000, 32'h40001, 32'h40002, 32'h40003, 32'h40003, 32'h40003};
    p_tab = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    v_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    d_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, pix_valid_o}, 32'd0);
    chk("rst_pix", {24'b0, pix_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    model_en = 1'b1;

    // four pixels from REG_OUT0, sink always ready; k counts edges after the start edge
    pix_ready_i = 1'b1;
    @(posedge CLK); #1;
    start_i  = 1'b1;
    region_i = REG_OUT0;
    count_i  = 17'd4;
    @(posedge CLK); #1;
    start_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      chk("t1_addr", mem_addr_o, a_tab[k]);
      chk("t1_valid", {31'b0, pix_valid_o}, {31'b0, v_tab[k]});
      chk("t1_busy", {31'b0, busy_o}, {31'b0, b_tab[k]});
      chk("t1_done", {31'b0, done_o}, {31'b0, d_tab[k]});
      if (v_tab[k]) chk("t1_pix", {24'b0, pix_o}, {24'b0, p_tab[k]});
`ifdef IMG_STREAM_CHECKSUM_EN
      if (k == 6) chk("t1_checksum", {16'b0, checksum_o}, 32'h00AA);
`endif
    end
    @(posedge CLK); #1;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    run_xfer(REG_IN1, 17'd10, 1, 100);

    // zero-length start: done only, no reads, never busy
    @(posedge CLK); #1;
    start_i  = 1'b1;
    region_i = REG_GENERAL;
    count_i  = 17'd0;
    @(posedge CLK); #1;
    start_i = 1'b0;
    @(negedge CLK);
    chk("z_done", {31'b0, done_o}, 32'd1);
    chk("z_busy", {31'b0, busy_o}, 32'd0);
    @(negedge CLK);
    chk("z_done_end", {31'b0, done_o}, 32'd0);
    chk("z_busy_end", {31'b0, busy_o}, 32'd0);
    @(posedge CLK); #1;

    // reset in the middle of a 20-pixel transfer
    start_i  = 1'b1;
    region_i = REG_IN0;
    count_i  = 17'd20;
    @(posedge CLK); #1;
    start_i = 1'b0;
    repeat (8) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_valid", {31'b0, pix_valid_o}, 32'd0);
    chk("mr_busy", {31'b0, busy_o}, 32'd0);
    chk("mr_addr", mem_addr_o, 32'h0);
    chk("mr_pix", {24'b0, pix_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("mr_no_done", {31'b0, done_o}, 32'd0);
    end
    run_xfer(REG_IN2, 17'd3, 0, 50);

    run_xfer(REG_OUT2, 17'd8, 2, 60);

`ifdef IMG_STREAM_CHECKSUM_EN
    for (int i = 0; i < 300; i++) mem[i] = 8'hFF;
    run_xfer(REG_OUT1, 17'd300, 0, 400);
    chk("checksum_done", {16'b0, cs_at_done}, 32'h2AD4);
    chk("checksum_hold", {16'b0, checksum_o}, 32'h2AD4);
`endif

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
